agg_col_sequencer: RTL and testbench

//  Sequences the shared adjacency-aggregation MAC datapath between two first-layer PE lanes.

---
 rtl/agg_col_sequencer.sv | 179 +++++++++++++++++
 tb/tb_agg_col_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/agg_col_sequencer.sv
// Sequences the shared aggregation MAC between two PE lanes: round-robin grant, N*N MAC walk, N-result drain.
// Latency: grant -> first MAC issue 1 cycle; >=2 cycles per (elem,row) pair; done 1 cycle after last drain beat.
// Backpressure: MAC stalls in WAIT until i_mac_done; drain holds o_out_idx while i_out_ready is low.
// Optional build macro AGG_SKIP_ZERO_EN: pairs whose adjacency bit is 0 are skipped without a MAC issue.
module agg_col_sequencer #(
  parameter int N    = 100,
  parameter int DW   = 16,
  parameter int IDXW = 3,
  parameter int CW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_1,
  input  logic            i_req_2,
  input  logic [IDXW-1:0] i_col_idx_1,
  input  logic [IDXW-1:0] i_col_idx_2,
  output logic            o_gnt_1,
  output logic            o_gnt_2,
  output logic            o_lane,
  output logic [IDXW-1:0] o_col_idx,
  output logic            o_busy,
  output logic            o_acc_clr,
  output logic [CW-1:0]   o_elem,
  output logic [CW-1:0]   o_row,
  input  logic            i_adj_bit,
  output logic            o_mac_valid,
  input  logic            i_mac_done,
  output logic            o_out_valid,
  output logic [CW-1:0]   o_out_idx,
  input  logic            i_out_ready,
  output logic            o_done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            state, state_nxt;
  logic              rr_ptr, rr_nxt;     // 0 = lane 1 wins a tie, 1 = lane 2 wins
  logic              gnt_1_nxt, gnt_2_nxt, lane_nxt, busy_nxt, acc_clr_nxt;
  logic [IDXW-1:0]   col_idx_nxt;
  logic [CW-1:0]     elem_nxt, row_nxt, out_idx_nxt;
  logic              mac_valid_nxt, out_valid_nxt, done_nxt;

  logic              pick_2;
  logic              row_wrap, last_pair;
  logic [CW-1:0]     row_adv, elem_adv;
  logic              unused_tie;

  // DW documents the datapath width only; i_adj_bit is dead in the default build.
  assign unused_tie = (DW > 0) && i_adj_bit;

  assign pick_2    = i_req_2 && (!i_req_1 || rr_ptr);
  assign row_wrap  = (o_row == LAST);
  assign last_pair = row_wrap && (o_elem == LAST);
  assign row_adv   = row_wrap ? '0 : o_row + 1'b1;
  assign elem_adv  = row_wrap ? ((o_elem == LAST) ? '0 : o_elem + 1'b1) : o_elem;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt     = state;
    rr_nxt        = rr_ptr;
    gnt_1_nxt     = 1'b0;
    gnt_2_nxt     = 1'b0;
    lane_nxt      = o_lane;
    col_idx_nxt   = o_col_idx;
    busy_nxt      = o_busy;
    acc_clr_nxt   = 1'b0;
    elem_nxt      = o_elem;
    row_nxt       = o_row;
    mac_valid_nxt = 1'b0;
    out_valid_nxt = 1'b0;
    out_idx_nxt   = o_out_idx;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (i_req_1 || i_req_2) begin
          gnt_1_nxt   = !pick_2;
          gnt_2_nxt   = pick_2;
          lane_nxt    = pick_2;
          col_idx_nxt = pick_2 ? i_col_idx_2 : i_col_idx_1;
          busy_nxt    = 1'b1;
          acc_clr_nxt = 1'b1;
          elem_nxt    = '0;
          row_nxt     = '0;
          out_idx_nxt = '0;
          // The pointer only moves on a contested grant.
          if (i_req_1 && i_req_2) rr_nxt = !pick_2;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
`ifdef AGG_SKIP_ZERO_EN
        if (!i_adj_bit) begin
          elem_nxt = elem_adv;
          row_nxt  = row_adv;
          if (last_pair) begin
            out_valid_nxt = 1'b1;
            out_idx_nxt   = '0;
            state_nxt     = DRAIN;
          end
        end else begin
          mac_valid_nxt = 1'b1;
          state_nxt     = WAIT;
        end
`else
        mac_valid_nxt = 1'b1;
        state_nxt     = WAIT;
`endif
      end
      WAIT: begin
        if (i_mac_done) begin
          elem_nxt = elem_adv;
          row_nxt  = row_adv;
          if (last_pair) begin
            out_valid_nxt = 1'b1;
            out_idx_nxt   = '0;
            state_nxt     = DRAIN;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      DRAIN: begin
        out_valid_nxt = 1'b1;
        if (o_out_valid && i_out_ready) begin
          if (o_out_idx == LAST) begin
            out_valid_nxt = 1'b0;
            done_nxt      = 1'b1;
            state_nxt     = DONE;
          end else begin
            out_idx_nxt = o_out_idx + 1'b1;
          end
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, arbitration pointer and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      o_gnt_1     <= 1'b0;
      o_gnt_2     <= 1'b0;
      o_lane      <= 1'b0;
      o_col_idx   <= '0;
      o_busy      <= 1'b0;
      o_acc_clr   <= 1'b0;
      o_elem      <= '0;
      o_row       <= '0;
      o_mac_valid <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_idx   <= '0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_nxt;
      o_gnt_1     <= gnt_1_nxt;
      o_gnt_2     <= gnt_2_nxt;
      o_lane      <= lane_nxt;
      o_col_idx   <= col_idx_nxt;
      o_busy      <= busy_nxt;
      o_acc_clr   <= acc_clr_nxt;
      o_elem      <= elem_nxt;
      o_row       <= row_nxt;
      o_mac_valid <= mac_valid_nxt;
      o_out_valid <= out_valid_nxt;
      o_out_idx   <= out_idx_nxt;
      o_done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_agg_col_sequencer.sv
// Directed bench for agg_col_sequencer at N=4: reset, single jobs, arbitration, drain stalls,
// mid-job reset and the adjacency-skip build option.
module tb_agg_col_sequencer;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int IDXW = 3;
  localparam int CW   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_req_1, i_req_2;
  logic [IDXW-1:0] i_col_idx_1, i_col_idx_2;
  logic            o_gnt_1, o_gnt_2, o_lane, o_busy, o_acc_clr;
  logic [IDXW-1:0] o_col_idx;
  logic [CW-1:0]   o_elem, o_row, o_out_idx;
  logic            i_adj_bit, o_mac_valid, i_mac_done;
  logic            o_out_valid, i_out_ready, o_done;

  int n_asrt = 0;
  int n_fail = 0;
  bit adj_mode = 1'b0;  // 0: adj = (elem==row), 1: adj = (row==0)

  always #5 clk = ~clk;

  // Adjacency ROM stand-in, combinational on the current pair.
  assign i_adj_bit = adj_mode ? (o_row == '0) : (o_elem == o_row);

  agg_col_sequencer #(.N(N), .DW(DW), .IDXW(IDXW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .i_req_1(i_req_1), .i_req_2(i_req_2),
    .i_col_idx_1(i_col_idx_1), .i_col_idx_2(i_col_idx_2),
    .o_gnt_1(o_gnt_1), .o_gnt_2(o_gnt_2),
    .o_lane(o_lane), .o_col_idx(o_col_idx), .o_busy(o_busy), .o_acc_clr(o_acc_clr),
    .o_elem(o_elem), .o_row(o_row), .i_adj_bit(i_adj_bit),
    .o_mac_valid(o_mac_valid), .i_mac_done(i_mac_done),
    .o_out_valid(o_out_valid), .o_out_idx(o_out_idx), .i_out_ready(i_out_ready),
    .o_done(o_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whether the bench expects pair m (row-major) to produce a MAC issue.
  function automatic bit is_issued(input int m);
    int e, r;
    e = m / N;
    r = m % N;
`ifdef AGG_SKIP_ZERO_EN
    return adj_mode ? (r == 0) : (e == r);
`else
    return (e >= 0) && (r >= 0);
`endif
  endfunction

  function automatic int exp_mac_count();
    int cnt = 0;
    for (int m = 0; m < N * N; m++) if (is_issued(m)) cnt++;
    return cnt;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk(tag, {o_gnt_1, o_gnt_2, o_lane, o_col_idx, o_busy, o_acc_clr, o_elem, o_row,
              o_mac_valid, o_out_valid, o_out_idx, o_done}, 64'd0);
  endtask

  // Runs one job from grant to done; the granted lane's request must already be high.
  task automatic run_job(input string name, input bit lane2, input logic [IDXW-1:0] idx,
                         input logic [15:0] pat, input int pat_len, input bit rereq);
    int cyc = 0, gnt_cyc = -1, macs = 0, xfers = 0, pat_pos = 0;
    int last_xfer = -100, done_cyc = -1, dones = 0, m = 0;
    logic pend = 1'b0, rdy;
    logic [CW-1:0] pe, pr;
    while (cyc < 400) begin
      @(negedge clk);
      i_mac_done = pend;
      pend = o_mac_valid;
      if (gnt_cyc < 0) begin
        if (o_gnt_1 || o_gnt_2) begin
          gnt_cyc = cyc;
          chk({name, "_gnt"}, {o_gnt_2, o_gnt_1}, lane2 ? 2'b10 : 2'b01);
          chk({name, "_grant_regs"}, {o_acc_clr, o_busy, o_lane, o_col_idx, o_mac_valid},
              {1'b1, 1'b1, lane2, idx, 1'b0});
          if (lane2) i_req_2 = 1'b0; else i_req_1 = 1'b0;
        end
      end else begin
        if (cyc == gnt_cyc + 1)
          chk({name, "_first_issue"}, {o_mac_valid, o_gnt_1, o_gnt_2, o_acc_clr}, 4'b1000);
        if (rereq && cyc == gnt_cyc + 2) begin
          if (lane2) i_req_2 = 1'b1; else i_req_1 = 1'b1;
        end
        if (o_mac_valid) begin
          while (m < N * N && !is_issued(m)) m++;
          pe = CW'(m / N);
          pr = CW'(m % N);
          chk({name, "_pair"}, {o_elem, o_row}, {pe, pr});
          m++;
          macs++;
        end
        if (o_out_valid) begin
          chk({name, "_drain_idx"}, o_out_idx, xfers);
          rdy = (pat_pos < pat_len) ? pat[pat_pos] : 1'b1;
          pat_pos++;
          i_out_ready = rdy;
          if (rdy) begin
            xfers++;
            last_xfer = cyc;
          end
        end else begin
          i_out_ready = 1'b0;
        end
        if (o_done) begin
          dones++;
          if (done_cyc < 0) begin
            done_cyc = cyc;
            chk({name, "_busy_at_done"}, o_busy, 1'b1);
          end
        end
        if (done_cyc >= 0 && cyc == done_cyc + 1) begin
          chk({name, "_after_done"}, {o_busy, o_done, o_out_valid}, 3'b000);
          break;
        end
      end
      cyc++;
    end
    i_mac_done  = 1'b0;
    i_out_ready = 1'b0;
    chk({name, "_granted"}, gnt_cyc >= 0, 1'b1);
    chk({name, "_mac_count"}, macs, exp_mac_count());
    chk({name, "_xfers"}, xfers, N);
    chk({name, "_done_count"}, dones, 1);
    chk({name, "_done_latency"}, done_cyc - last_xfer, 1);
  endtask

  initial begin
    bit found;
    logic pend;
    rst = 1'b1;
    i_req_1 = 1'b0; i_req_2 = 1'b0;
    i_col_idx_1 = '0; i_col_idx_2 = '0;
    i_mac_done = 1'b0; i_out_ready = 1'b0;

    // 1: reset held 3 cycles, then idle with no requests
    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_all_zero("idle_no_req");
    end

    // 2: single lane-1 job, column 5, ready held high
    i_col_idx_1 = 3'd5;
    i_req_1 = 1'b1;
    run_job("single", 1'b0, 3'd5, 16'hffff, 0, 1'b0);

    // 3: both lanes request; strict alternation while both keep requesting
    i_col_idx_1 = 3'd1;
    i_col_idx_2 = 3'd2;
    i_req_1 = 1'b1;
    i_req_2 = 1'b1;
    run_job("alt_a", 1'b0, 3'd1, 16'hffff, 0, 1'b1);
    run_job("alt_b", 1'b1, 3'd2, 16'hffff, 0, 1'b1);
    run_job("alt_c", 1'b0, 3'd1, 16'hffff, 0, 1'b0);
    run_job("alt_d", 1'b1, 3'd2, 16'hffff, 0, 1'b0);

    // 4: drain with ready pattern 1,0,0,1,1,0,1 on a solo lane-1 job
    i_col_idx_1 = 3'd3;
    i_req_1 = 1'b1;
    run_job("drain_stall", 1'b0, 3'd3, 16'b1011001, 7, 1'b0);

    // Solo grants left the pointer on lane 2, so a tie now goes to lane 2
    i_col_idx_2 = 3'd4;
    i_req_1 = 1'b1;
    i_req_2 = 1'b1;
    run_job("ptr_hold_2", 1'b1, 3'd4, 16'hffff, 0, 1'b0);
    run_job("ptr_hold_1", 1'b0, 3'd3, 16'hffff, 0, 1'b0);

    // 5: reset while waiting on pair (2,1), followed by a late mac done
    i_col_idx_1 = 3'd6;
    i_req_1 = 1'b1;
    found = 1'b0;
    pend = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      i_mac_done = pend;
      pend = o_mac_valid;
      if (o_gnt_1) i_req_1 = 1'b0;
      if (o_mac_valid && o_elem == 8'd2 && o_row == 8'd1) found = 1'b1;
    end
    chk("rst_reach_wait_2_1", found, 1'b1);
    rst = 1'b1;
    i_mac_done = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid_job");
    rst = 1'b0;
    i_mac_done = 1'b1;
    @(negedge clk);
    i_mac_done = 1'b0;
    chk_all_zero("late_done_ignored");
    @(negedge clk);
    chk_all_zero("idle_after_rst");
    i_req_1 = 1'b1;
    run_job("restart", 1'b0, 3'd6, 16'hffff, 0, 1'b0);

    // 6: sparse adjacency (row 0 only); the final pair is a zero entry
    adj_mode = 1'b1;
    i_col_idx_2 = 3'd7;
    i_req_2 = 1'b1;
    run_job("sparse", 1'b1, 3'd7, 16'hffff, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
